// File: rtl/uart_rx_char.sv
// UART character receiver: 2-flop synchronized rxd, 8 data bits LSB-first, one stop bit,
// single-entry holding register with ready/valid handoff. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_char #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic          sync1_reg, sync2_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          armed_reg, armed_next;
  logic          complete, bad_frame, tick;
`ifdef UART_RX_PARITY_EN
  logic          par_err_reg, par_err_next;
`endif

  assign tick = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    complete   = 1'b0;
    bad_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_next = par_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (armed_reg && !sync2_reg) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
          bit_next   = 3'd0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (!sync2_reg) begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          shift_next = {sync2_reg, shift_reg[7:1]};
          cnt_next   = FULL_LOAD;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          // Even parity: data bits plus parity bit must hold an even count of ones.
          par_err_next = (^shift_reg) ^ sync2_reg;
          cnt_next     = FULL_LOAD;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = IDLE;
`ifdef UART_RX_PARITY_EN
          complete  = sync2_reg && !par_err_reg;
          bad_frame = !sync2_reg || par_err_reg;
`else
          complete  = sync2_reg;
          bad_frame = !sync2_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    // Start edges only count after the line has been seen high while idle.
    armed_next = (state_reg == IDLE) && (state_next == IDLE) && (armed_reg || sync2_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      armed_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_reg <= 1'b0;
`endif
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      armed_reg <= armed_next;
`ifdef UART_RX_PARITY_EN
      par_err_reg <= par_err_next;
`endif
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= bad_frame;
      overrun   <= complete && rx_valid && !rx_ready;
    end
  end

endmodule

// File: tb/tb_uart_rx_char.sv
// Bench for uart_rx_char: directed frames, a frame-level scoreboard model checked every cycle,
// and literal expectations per scenario. Honors UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_char;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx_char #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  typedef struct {
    int         edge_no;
    bit         ok;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  int         cyc = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  int         n_checks = 0, n_fail = 0;
  int         valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, acc_cnt = 0;
  logic [7:0] acc_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each frame resolves at its stop-bit sample edge, then the
  // holding-register rules decide load / overrun / discard.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      evq.delete();
    end else begin
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (evq.size() > 0 && evq[0].edge_no == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) m_ferr = 1'b1;
        else if (!m_valid || rx_ready) begin
          m_valid = 1'b1;
          m_data  = ev.data;
        end else m_ovr = 1'b1;
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_data", rx_data, m_data);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    if (rx_valid) valid_cycles++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && rx_ready && rst_n) begin
      acc_cnt++;
      acc_last = rx_data;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the start bit is seen at the next posedge k. Synchronizer (2) plus
  // half a bit to the start sample, then NB-1 full bits to the stop sample.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par);
    logic ok;
    logic par;
    par = (^d) ^ flip_par;
    ok  = stop_bit;
`ifdef UART_RX_PARITY_EN
    if ((^{d, par}) != 1'b0) ok = 1'b0;
`endif
    evq.push_back('{edge_no: cyc + 1 + 2 + H + (NB - 1) * N, ok: ok, data: d});
    drive_bit(1'b0, N);
    for (int i = 0; i < 8; i++) drive_bit(d[i], N);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, N);
`endif
    drive_bit(stop_bit, N);
    rxd = 1'b1;
  endtask

  int vc0, a0, f0, o0;
  logic [7:0] abort_d;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    repeat (2 * N) @(negedge clk);

    // 0x61 with consumer always ready
    rx_ready = 1'b1;
    vc0 = valid_cycles; a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h61, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("s1_valid_cycles", valid_cycles - vc0, 1);
    chk("s1_accepted", acc_cnt - a0, 1);
    chk("s1_data", acc_last, 8'h61);
    chk("s1_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    $display("txn 0x61 ready=1 -> accepted 0x%0h", acc_last);

    // 0x7A then 0x41 back-to-back, consumer stalled: second is an overrun
    rx_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h7A, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("s2_valid_held", rx_valid, 1);
    chk("s2_data_held", rx_data, 8'h7A);
    chk("s2_overrun_pulses", ovr_cnt - o0, 1);
    chk("s2_no_ferr", ferr_cnt - f0, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("s2_drain_data", acc_last, 8'h7A);
    chk("s2_drain_count", acc_cnt - a0, 1);
    chk("s2_valid_cleared", rx_valid, 0);
    $display("txn 0x7A,0x41 stalled -> kept 0x%0h, overruns %0d", acc_last, ovr_cnt - o0);

    // 0x55 with stop bit low, then 0x62 held for the consumer
    rx_ready = 1'b1;
    vc0 = valid_cycles; a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (2 * N) @(negedge clk);
    chk("s3_ferr_pulses", ferr_cnt - f0, 1);
    chk("s3_no_valid", valid_cycles - vc0, 0);
    rx_ready = 1'b0;
    send_frame(8'h62, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("s3_next_valid", rx_valid, 1);
    chk("s3_next_data", rx_data, 8'h62);
    $display("txn 0x55 bad stop -> frame_err %0d; then 0x%0h", ferr_cnt - f0, rx_data);

    // 5-cycle low glitch on idle line
    f0 = ferr_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * N) @(negedge clk);
    chk("s4_data_kept", rx_data, 8'h62);
    chk("s4_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    $display("txn glitch 5 cycles -> data 0x%0h, flags %0d", rx_data, (ferr_cnt - f0) + (ovr_cnt - o0));

    // reset during data bit 4 of 0x63, then 0x64
    abort_d = 8'h63;
    drive_bit(1'b0, N);
    for (int i = 0; i < 4; i++) drive_bit(abort_d[i], N);
    drive_bit(abort_d[4], H);
    rst_n = 1'b0;
    rxd = 1'b1;
    #2;
    chk("s5_rst_valid", rx_valid, 0);
    chk("s5_rst_data", rx_data, 0);
    chk("s5_rst_ferr", frame_err, 0);
    chk("s5_rst_ovr", overrun, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * N) @(negedge clk);
    rx_ready = 1'b1;
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h64, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("s5_after_data", acc_last, 8'h64);
    chk("s5_after_count", acc_cnt - a0, 1);
    chk("s5_after_no_ferr", ferr_cnt - f0, 0);
    $display("txn reset mid 0x63, then 0x64 -> accepted 0x%0h", acc_last);

`ifdef UART_RX_PARITY_EN
    // 0x03 parity 0 is even; 0x07 parity 0 is not
    a0 = acc_cnt; f0 = ferr_cnt;
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("p1_data", acc_last, 8'h03);
    chk("p1_count", acc_cnt - a0, 1);
    $display("txn 0x03 par=0 -> accepted 0x%0h", acc_last);
    a0 = acc_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("p2_ferr", ferr_cnt - f0, 1);
    chk("p2_no_accept", acc_cnt - a0, 0);
    $display("txn 0x07 par=0 -> frame_err %0d", ferr_cnt - f0);
`endif

    repeat (N) @(negedge clk);
    chk("events_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_char.md
UART_RX_CHAR -- requirements
Module: uart_rx_char

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit period; legal range 4..1023.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rxd  input  1  asynchronous serial line; idles high; LSB-first.
REQ-005 rx_data  output  8  received character; bit 0 is LSB; drives the case-conversion stage inputs directly.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed character.
REQ-007 rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: new character lost because holding register full.

Function
REQ-010 rxd passes through a 2-flop synchronizer before any use; synchronizer latency counts toward all timing below.
REQ-011 FSM states: IDLE, START, DATA, STOP (plus PARITY when configured); IDLE on reset.
REQ-012 IDLE -> START on a synchronized high-to-low transition; bit counter cleared, baud counter loaded.
REQ-013 START: sample at CLKS_PER_BIT/2 (integer division) cycles after the edge; low -> DATA; high -> IDLE (glitch reject, no flags).
REQ-014 DATA: 8 samples, each CLKS_PER_BIT cycles after the previous; shift in LSB first; after 8th -> STOP (or PARITY).
REQ-015 STOP: sample CLKS_PER_BIT cycles after last data/parity sample; high -> character complete; low -> frame_err pulse, character discarded.
REQ-016 After STOP, return to IDLE; a new start edge is recognised only after the line has been seen high at least once in IDLE.
REQ-017 On completion with rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: rx_data loaded, rx_valid=1 on the next cycle.
REQ-018 On completion with rx_valid=1 and rx_ready=0: new character dropped, rx_data unchanged, overrun pulses one cycle.
REQ-019 rx_valid=1 and rx_ready=1 without completion: rx_valid cleared next cycle; rx_data held.
REQ-020 rx_data stable while rx_valid=1 and not accepted.
REQ-021 Continuous back-to-back frames (stop bit immediately followed by start bit) received without loss.

Reset
REQ-022 rst_n low asynchronously forces: FSM IDLE, synchronizer flops high, counters 0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
REQ-023 Reset mid-frame abandons the frame; no flags; after release the receiver waits for line high then a fresh start edge.
REQ-024 Reset release synchronous to clk edges; no output changes in the release cycle.

Configuration
REQ-025 Macro UART_RX_PARITY_EN: when defined, a PARITY state sits between DATA and STOP expecting even parity over the 8 data bits.
REQ-026 With UART_RX_PARITY_EN, parity mismatch discards the character and pulses frame_err (same output, no extra port); frame length 11 bits.
REQ-027 Without UART_RX_PARITY_EN, no PARITY state or logic exists; frame is 8N1, 10 bits.

Verification
REQ-028 CLKS_PER_BIT=16, 8N1, send 0x61 with rx_ready=1 -> rx_valid one cycle, rx_data=0x61, no flags.
REQ-029 Send 0x7A then 0x41 back-to-back, rx_ready=0 until both done -> rx_data=0x7A, overrun pulses once at second stop, 0x41 lost.
REQ-030 Send 0x55 with stop bit forced low -> frame_err one pulse, rx_valid stays 0; next frame 0x62 received correctly.
REQ-031 Low glitch of 5 cycles on idle line -> no rx_valid, no flags, FSM back in IDLE.
REQ-032 Assert rst_n low during data bit 4 of 0x63 -> all outputs reset values; following frame 0x64 received as 0x64.
REQ-033 UART_RX_PARITY_EN defined: 0x03 with parity 0 -> accepted; 0x07 with parity 0 -> frame_err, no rx_valid.
